// File: rtl/return_stack_pkg.sv
// Shared FRANK6000 return-stack constants, overflow-mode encodings and the
// per-edge operation decoder used by the stack control logic.
package return_stack_pkg;

  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_RETURN_OFFSET = 1;

  typedef enum logic {
    STACK_DROP = 1'b0,
    STACK_WRAP = 1'b1
  } ovf_mode_e;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_DROP,
    OP_WRAP,
    OP_POP,
    OP_UNDER,
    OP_XCHG,
    OP_PUSH_UNDER
  } stack_op_e;

  // Collapses call/return strobes and stack occupancy into one operation.
  function automatic stack_op_e decode_op(input logic call,
                                          input logic rtrn,
                                          input logic empty,
                                          input logic full,
                                          input logic wrap_en);
    if (call && rtrn) return empty ? OP_PUSH_UNDER : OP_XCHG;
    if (call) begin
      if (!full) return OP_PUSH;
      return wrap_en ? OP_WRAP : OP_DROP;
    end
    if (rtrn) return empty ? OP_UNDER : OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Call/return strobes and status bundle between the PC control path (master)
// and the return-address stack (slave).
interface return_stack_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] i_pc;
  logic                  i_call;
  logic                  i_rtrn;
  logic                  i_err_clr;
  logic [DATA_WIDTH-1:0] or_stack;
  logic                  or_rtrn_vld;
  logic [ADDR_WIDTH:0]   o_depth;
  logic                  o_empty;
  logic                  o_full;
  logic                  or_overflow;
  logic                  or_underflow;

  modport master (
    output i_pc, i_call, i_rtrn, i_err_clr,
    input  or_stack, or_rtrn_vld, o_depth, o_empty, o_full, or_overflow, or_underflow
  );

  modport slave (
    input  i_pc, i_call, i_rtrn, i_err_clr,
    output or_stack, or_rtrn_vld, o_depth, o_empty, o_full, or_overflow, or_underflow
  );

endinterface

// File: rtl/return_stack_mem.sv
// Return-address storage: one synchronous write port, one combinational read
// port so the top-of-stack is available in the same cycle as the pop request.
module stack_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack: pushes pc+offset on call, pops into a
// registered output on return, with depth status and sticky error flags.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RETURN_OFFSET = DEF_RETURN_OFFSET,
  parameter int OVF_WRAP      = int'(STACK_DROP)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  return_stack_if.slave  bus
);

  localparam bit                  WRAP_EN  = (OVF_WRAP == int'(STACK_WRAP));
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] stack_q, stack_d;
  logic                  rtrn_vld_q, rtrn_vld_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic [DATA_WIDTH-1:0] push_val;
  logic                  is_empty;
  logic                  is_full;
  stack_op_e             op;

  assign top_addr = sp_q - ADDR_WIDTH'(1);
  assign push_val = bus.i_pc + DATA_WIDTH'(RETURN_OFFSET);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_FULL);
  assign op       = decode_op(bus.i_call, bus.i_rtrn, is_empty, is_full, WRAP_EN);

  // Memory writes are suppressed during reset so a call held in reset is lost.
  stack_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (mem_we & i_rst_n),
    .waddr_i (mem_waddr),
    .wdata_i (push_val),
    .raddr_i (top_addr),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    stack_d    = stack_q;
    rtrn_vld_d = 1'b0;
    ovf_d      = ovf_q & ~bus.i_err_clr;
    udf_d      = udf_q & ~bus.i_err_clr;
    mem_we     = 1'b0;
    mem_waddr  = sp_q;
    case (op)
      OP_PUSH: begin
        mem_we = 1'b1;
        sp_d   = sp_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q + (ADDR_WIDTH+1)'(1);
      end
      OP_PUSH_UNDER: begin
        mem_we = 1'b1;
        sp_d   = sp_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q + (ADDR_WIDTH+1)'(1);
        udf_d  = 1'b1;
      end
      OP_DROP: begin
        ovf_d = 1'b1;
      end
      OP_WRAP: begin
        // sp already points at the oldest entry when the stack is full.
        mem_we = 1'b1;
        sp_d   = sp_q + ADDR_WIDTH'(1);
        ovf_d  = 1'b1;
      end
      OP_POP: begin
        stack_d    = mem_rdata;
        sp_d       = top_addr;
        cnt_d      = cnt_q - (ADDR_WIDTH+1)'(1);
        rtrn_vld_d = 1'b1;
      end
      OP_UNDER: begin
        udf_d = 1'b1;
      end
      OP_XCHG: begin
        stack_d    = mem_rdata;
        mem_we     = 1'b1;
        mem_waddr  = top_addr;
        rtrn_vld_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sp_q       <= '0;
      cnt_q      <= '0;
      stack_q    <= '0;
      rtrn_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      stack_q    <= stack_d;
      rtrn_vld_q <= rtrn_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.or_stack     = stack_q;
  assign bus.or_rtrn_vld  = rtrn_vld_q;
  assign bus.o_depth      = cnt_q;
  assign bus.o_empty      = is_empty;
  assign bus.o_full       = is_full;
  assign bus.or_overflow  = ovf_q;
  assign bus.or_underflow = udf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench driving a drop-mode and a wrap-mode stack (DEPTH 4) in lockstep.
module tb_return_stack;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  always #5 clk = ~clk;

  return_stack_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) ifd ();
  return_stack_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) ifw ();

  return_stack #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RETURN_OFFSET(1), .OVF_WRAP(0)) u_drop (
    .i_clk (clk), .i_rst_n (rst_n), .bus (ifd)
  );
  return_stack #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RETURN_OFFSET(1), .OVF_WRAP(1)) u_wrap (
    .i_clk (clk), .i_rst_n (rst_n), .bus (ifw)
  );

  task automatic step(input logic call, input logic rtrn, input logic clr, input logic [7:0] pc);
    ifd.i_call = call; ifd.i_rtrn = rtrn; ifd.i_err_clr = clr; ifd.i_pc = pc;
    ifw.i_call = call; ifw.i_rtrn = rtrn; ifw.i_err_clr = clr; ifw.i_pc = pc;
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d rst_n=%b call=%b rtrn=%b clr=%b pc=%h | drop stk=%h vld=%b dep=%0d ovf=%b udf=%b | wrap stk=%h vld=%b dep=%0d ovf=%b udf=%b",
             cycle, rst_n, call, rtrn, clr, pc,
             ifd.or_stack, ifd.or_rtrn_vld, ifd.o_depth, ifd.or_overflow, ifd.or_underflow,
             ifw.or_stack, ifw.or_rtrn_vld, ifw.o_depth, ifw.or_overflow, ifw.or_underflow);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h55);
    step(1'b1, 1'b0, 1'b0, 8'h56);
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d/%0d exp=0", ifd.o_depth, ifw.o_depth); end
    checks++; if (ifd.o_empty !== 1'b1 || ifw.o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b/%b exp=1", ifd.o_empty, ifw.o_empty); end
    checks++; if (ifd.or_stack !== 8'h00 || ifw.or_stack !== 8'h00) begin failures++; $display("FAIL reset_stack got=%h/%h exp=00", ifd.or_stack, ifw.or_stack); end
    checks++; if ({ifd.or_rtrn_vld, ifd.or_overflow, ifd.or_underflow, ifd.o_full} !== 4'b0 ||
                  {ifw.or_rtrn_vld, ifw.or_overflow, ifw.or_underflow, ifw.o_full} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b%b/%b%b%b%b exp=0000",
        ifd.or_rtrn_vld, ifd.or_overflow, ifd.or_underflow, ifd.o_full,
        ifw.or_rtrn_vld, ifw.or_overflow, ifw.or_underflow, ifw.o_full);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0) begin failures++; $display("FAIL reset_call_lost got=%0d/%0d exp=0", ifd.o_depth, ifw.o_depth); end
  endtask

  task automatic test_push_pop();
    logic [7:0] pcs [3] = '{8'h10, 8'h20, 8'h30};
    logic [7:0] exp [3] = '{8'h31, 8'h21, 8'h11};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, pcs[i]);
      checks++; if (ifd.o_depth !== 3'(i + 1) || ifw.o_depth !== 3'(i + 1)) begin failures++; $display("FAIL push_depth[%0d] got=%0d/%0d exp=%0d", i, ifd.o_depth, ifw.o_depth, i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (ifd.or_stack !== exp[i] || ifw.or_stack !== exp[i]) begin failures++; $display("FAIL pop_order[%0d] got=%h/%h exp=%h", i, ifd.or_stack, ifw.or_stack, exp[i]); end
      checks++; if (ifd.or_rtrn_vld !== 1'b1 || ifw.or_rtrn_vld !== 1'b1) begin failures++; $display("FAIL pop_vld[%0d] got=%b/%b exp=1", i, ifd.or_rtrn_vld, ifw.or_rtrn_vld); end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (ifd.o_empty !== 1'b1 || ifw.o_empty !== 1'b1) begin failures++; $display("FAIL pop_empty got=%b/%b exp=1", ifd.o_empty, ifw.o_empty); end
    checks++; if (ifd.or_rtrn_vld !== 1'b0 || ifw.or_rtrn_vld !== 1'b0) begin failures++; $display("FAIL idle_vld got=%b/%b exp=0", ifd.or_rtrn_vld, ifw.or_rtrn_vld); end
    checks++; if (ifd.or_stack !== 8'h11 || ifw.or_stack !== 8'h11) begin failures++; $display("FAIL idle_hold got=%h/%h exp=11", ifd.or_stack, ifw.or_stack); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
    logic [7:0] exp_w [4] = '{8'h05, 8'h04, 8'h03, 8'h02};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 3) begin
        checks++; if (ifd.o_full !== 1'b1 || ifw.o_full !== 1'b1 || ifd.or_overflow !== 1'b0 || ifw.or_overflow !== 1'b0) begin
          failures++; $display("FAIL fill_full full=%b/%b ovf=%b/%b exp full=1 ovf=0", ifd.o_full, ifw.o_full, ifd.or_overflow, ifw.or_overflow);
        end
      end
    end
    checks++; if (ifd.or_overflow !== 1'b1 || ifw.or_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b/%b exp=1", ifd.or_overflow, ifw.or_overflow); end
    checks++; if (ifd.o_depth !== 3'd4 || ifw.o_depth !== 3'd4 || ifd.o_full !== 1'b1 || ifw.o_full !== 1'b1) begin
      failures++; $display("FAIL ovf_depth got=%0d/%0d full=%b/%b exp=4 full=1", ifd.o_depth, ifw.o_depth, ifd.o_full, ifw.o_full);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (ifd.or_stack !== exp_d[i]) begin failures++; $display("FAIL ovf_drop_pop[%0d] got=%h exp=%h", i, ifd.or_stack, exp_d[i]); end
      checks++; if (ifw.or_stack !== exp_w[i]) begin failures++; $display("FAIL ovf_wrap_pop[%0d] got=%h exp=%h", i, ifw.or_stack, exp_w[i]); end
    end
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0) begin failures++; $display("FAIL ovf_drain got=%0d/%0d exp=0", ifd.o_depth, ifw.o_depth); end
    checks++; if (ifd.or_overflow !== 1'b1 || ifw.or_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b/%b exp=1", ifd.or_overflow, ifw.or_overflow); end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (ifd.or_overflow !== 1'b0 || ifw.or_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b/%b exp=0", ifd.or_overflow, ifw.or_overflow); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (ifd.or_underflow !== 1'b1 || ifw.or_underflow !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b/%b exp=1", ifd.or_underflow, ifw.or_underflow); end
    checks++; if (ifd.or_rtrn_vld !== 1'b0 || ifw.or_rtrn_vld !== 1'b0) begin failures++; $display("FAIL udf_vld got=%b/%b exp=0", ifd.or_rtrn_vld, ifw.or_rtrn_vld); end
    checks++; if (ifd.or_stack !== 8'h01 || ifw.or_stack !== 8'h02) begin failures++; $display("FAIL udf_hold got=%h/%h exp=01/02", ifd.or_stack, ifw.or_stack); end
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0) begin failures++; $display("FAIL udf_depth got=%0d/%0d exp=0", ifd.o_depth, ifw.o_depth); end
    step(1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (ifd.or_underflow !== 1'b1 || ifw.or_underflow !== 1'b1) begin failures++; $display("FAIL udf_set_wins got=%b/%b exp=1", ifd.or_underflow, ifw.or_underflow); end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (ifd.or_underflow !== 1'b0 || ifw.or_underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b/%b exp=0", ifd.or_underflow, ifw.or_underflow); end
  endtask

  task automatic test_tail_call();
    step(1'b1, 1'b0, 1'b0, 8'h40);
    step(1'b1, 1'b1, 1'b0, 8'h80);
    checks++; if (ifd.or_stack !== 8'h41 || ifw.or_stack !== 8'h41) begin failures++; $display("FAIL tail_stack got=%h/%h exp=41", ifd.or_stack, ifw.or_stack); end
    checks++; if (ifd.o_depth !== 3'd1 || ifw.o_depth !== 3'd1 || ifd.or_rtrn_vld !== 1'b1 || ifw.or_rtrn_vld !== 1'b1) begin
      failures++; $display("FAIL tail_depth got=%0d/%0d vld=%b/%b exp=1 vld=1", ifd.o_depth, ifw.o_depth, ifd.or_rtrn_vld, ifw.or_rtrn_vld);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (ifd.or_stack !== 8'h81 || ifw.or_stack !== 8'h81) begin failures++; $display("FAIL tail_pop got=%h/%h exp=81", ifd.or_stack, ifw.or_stack); end
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0) begin failures++; $display("FAIL tail_empty got=%0d/%0d exp=0", ifd.o_depth, ifw.o_depth); end
  endtask

  task automatic test_tail_call_full();
    logic [7:0] exp [3] = '{8'hA3, 8'hA2, 8'hA1};
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'hB0);
    checks++; if (ifd.or_stack !== 8'hA4 || ifw.or_stack !== 8'hA4) begin failures++; $display("FAIL xfull_stack got=%h/%h exp=a4", ifd.or_stack, ifw.or_stack); end
    checks++; if (ifd.or_overflow !== 1'b0 || ifw.or_overflow !== 1'b0 || ifd.o_depth !== 3'd4 || ifw.o_depth !== 3'd4) begin
      failures++; $display("FAIL xfull_noovf ovf=%b/%b depth=%0d/%0d exp ovf=0 depth=4", ifd.or_overflow, ifw.or_overflow, ifd.o_depth, ifw.o_depth);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (ifd.or_stack !== 8'hB1 || ifw.or_stack !== 8'hB1) begin failures++; $display("FAIL xfull_pop got=%h/%h exp=b1", ifd.or_stack, ifw.or_stack); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (ifd.or_stack !== exp[i] || ifw.or_stack !== exp[i]) begin failures++; $display("FAIL xfull_drain[%0d] got=%h/%h exp=%h", i, ifd.or_stack, ifw.or_stack, exp[i]); end
    end
  endtask

  task automatic test_call_rtrn_empty();
    step(1'b1, 1'b1, 1'b0, 8'h60);
    checks++; if (ifd.or_underflow !== 1'b1 || ifw.or_underflow !== 1'b1 || ifd.or_rtrn_vld !== 1'b0 || ifw.or_rtrn_vld !== 1'b0) begin
      failures++; $display("FAIL xempty_flags udf=%b/%b vld=%b/%b exp udf=1 vld=0", ifd.or_underflow, ifw.or_underflow, ifd.or_rtrn_vld, ifw.or_rtrn_vld);
    end
    checks++; if (ifd.o_depth !== 3'd1 || ifw.o_depth !== 3'd1 || ifd.or_stack !== 8'hA1 || ifw.or_stack !== 8'hA1) begin
      failures++; $display("FAIL xempty_push depth=%0d/%0d stk=%h/%h exp depth=1 stk=a1", ifd.o_depth, ifw.o_depth, ifd.or_stack, ifw.or_stack);
    end
    step(1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (ifd.or_stack !== 8'h61 || ifw.or_stack !== 8'h61) begin failures++; $display("FAIL xempty_pop got=%h/%h exp=61", ifd.or_stack, ifw.or_stack); end
  endtask

  task automatic test_reset_midseq();
    step(1'b1, 1'b0, 1'b0, 8'h70);
    step(1'b1, 1'b0, 1'b0, 8'h71);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h72);
    checks++; if (ifd.o_depth !== 3'd0 || ifw.o_depth !== 3'd0 || ifd.or_stack !== 8'h00 || ifw.or_stack !== 8'h00 || ifd.or_rtrn_vld !== 1'b0 || ifw.or_rtrn_vld !== 1'b0) begin
      failures++; $display("FAIL midrst depth=%0d/%0d stk=%h/%h vld=%b/%b exp 0", ifd.o_depth, ifw.o_depth, ifd.or_stack, ifw.or_stack, ifd.or_rtrn_vld, ifw.or_rtrn_vld);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (ifd.or_underflow !== 1'b1 || ifw.or_underflow !== 1'b1) begin failures++; $display("FAIL midrst_udf got=%b/%b exp=1", ifd.or_underflow, ifw.or_underflow); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_tail_call();
    test_tail_call_full();
    test_call_rtrn_empty();
    test_reset_midseq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_stack.md
# return_stack

Parametrised hardware return-address stack for the FRANK6000 control path, sitting beside the program counter. On a call it pushes `i_pc + RETURN_OFFSET`; on a return it pops the most recent entry into a registered output that the PC mux loads. It extends the first-generation instruction stack with:
- configurable depth and width;
- full/empty/depth status;
- sticky overflow/underflow errors;
- a selectable overflow mode (drop or circular overwrite);
- a defined simultaneous call+return (tail-call exchange).

## Interface
Parameters:
- `ADDR_WIDTH`, 4, log2 of stack depth; DEPTH = 2^ADDR_WIDTH entries.
- `DATA_WIDTH`, 8, width of the PC and of each stored return address.
- `RETURN_OFFSET`, 1, constant added to `i_pc` on push; modulo 2^DATA_WIDTH.
- `OVF_WRAP`, 0, overflow mode. 0 = drop the call when full; 1 = overwrite the oldest entry when full.

Ports:
- `i_clk` input 1: single clock; all state updates on its rising edge.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_pc` input DATA_WIDTH: current program counter.
- `i_call` input 1: push request, sampled each rising edge.
- `i_rtrn` input 1: pop request, sampled each rising edge.
- `i_err_clr` input 1: clears both sticky error flags.
- `or_stack` output DATA_WIDTH: registered return address from the last successful pop.
- `or_rtrn_vld` output 1: one-cycle pulse; `or_stack` was loaded this edge.
- `o_depth` output ADDR_WIDTH+1: number of valid entries, 0..DEPTH.
- `o_empty` output 1: `o_depth == 0`.
- `o_full` output 1: `o_depth == DEPTH`.
- `or_overflow` output 1: sticky; a call occurred while full.
- `or_underflow` output 1: sticky; a return occurred while empty.

## Operation
State:
- Storage array `mem[DEPTH]`.
- Write pointer `sp` (ADDR_WIDTH bits, wraps modulo DEPTH).
- Counter `cnt` (ADDR_WIDTH+1 bits).
- The top of stack is `mem[sp-1]`.

Reset (`i_rst_n == 0` at an edge):
- `sp`, `cnt`, `or_stack`, `or_rtrn_vld`, `or_overflow` and `or_underflow` all go to 0.
- `mem` is not reset.
- Reset overrides every other input in that cycle, including mid-sequence calls and returns.

Per edge, with `push_val = i_pc + RETURN_OFFSET` truncated to DATA_WIDTH:
- **Call only, not full:** `mem[sp] <= push_val`; `sp++`; `cnt++`.
- **Call only, full, OVF_WRAP=0:** no write; `sp` and `cnt` unchanged; `or_overflow <= 1`.
- **Call only, full, OVF_WRAP=1:** `mem[sp] <= push_val`, which overwrites the oldest entry; `sp++`; `cnt` stays DEPTH; `or_overflow <= 1`.
- **Return only, not empty:** `or_stack <= mem[sp-1]`; `sp--`; `cnt--`; `or_rtrn_vld <= 1`.
- **Return only, empty:** `or_stack` holds; `sp` and `cnt` unchanged; `or_underflow <= 1`; `or_rtrn_vld` stays 0.
- **Call and return, not empty (tail-call exchange):**
  - `or_stack <= mem[sp-1]` (old value) and `mem[sp-1] <= push_val`, in the same edge.
  - `sp` and `cnt` unchanged; `or_rtrn_vld <= 1`.
  - Never flags overflow, even when full.
- **Call and return, empty:** behaves as call only; `or_underflow <= 1`; `or_rtrn_vld` stays 0.
- **Neither:** all state holds; `or_rtrn_vld <= 0`.

Error clear and status:
- `i_err_clr` clears both sticky flags.
- If a new error event occurs in the same cycle as `i_err_clr`, the set wins.
- `o_depth`, `o_empty` and `o_full` are combinational from `cnt`.
- Pointer arithmetic wraps modulo DEPTH; `cnt` never exceeds DEPTH and never goes below 0.

## Timing
- Push latency: an entry written at edge N is poppable at edge N+1.
- Pop latency: `or_stack` and `or_rtrn_vld` are valid after the edge that sampled `i_rtrn`, i.e. one cycle.
- `or_stack` holds its value until the next successful pop.
- Back-to-back calls and returns at one per cycle are supported, with no bubbles.
- `o_depth`, `o_full` and `o_empty` reflect the state after the most recent edge.
- Sticky flags assert on the edge following the offending request.
- Inputs need only meet setup/hold to `i_clk`; there is no handshake beyond the single-cycle strobes.

## Structure
- The shared FRANK6000 header holds the default `ADDR_WIDTH`, `DATA_WIDTH` and `RETURN_OFFSET` constants and the `OVF_WRAP` mode encodings (`STACK_DROP = 0`, `STACK_WRAP = 1`).
- One sub-module, `stack_mem`: a DEPTH×DATA_WIDTH register array with one write port and one combinational read port.
- The pointer, counter and flag logic stay in `return_stack`.

## Test plan
All scenarios use ADDR_WIDTH=2 (DEPTH 4), DATA_WIDTH=8, RETURN_OFFSET=1.
- **Reset:** hold `i_rst_n=0` for 2 cycles with `i_call=1` → `o_depth=0`, `o_empty=1`, `or_stack=0x00`, all flags 0.
- **Push/pop order:** call with pc=0x10, 0x20, 0x30, then 3 returns → `or_stack` = 0x31, 0x21, 0x11 on successive cycles, `or_rtrn_vld=1` each cycle, `o_empty=1` at the end.
- **Overflow, drop mode (OVF_WRAP=0):** 5 calls with pc=0x00..0x04 → `o_full=1`, `or_overflow=1`; then 4 returns → 0x04, 0x03, 0x02, 0x01.
- **Overflow, wrap mode (OVF_WRAP=1):** same stimulus → 4 returns give 0x05, 0x04, 0x03, 0x02; `o_depth=0` after.
- **Underflow:** return on an empty stack → `or_underflow=1`, `or_rtrn_vld=0`, `or_stack` unchanged. Then `i_err_clr=1` together with another empty return → flag stays 1. Then `i_err_clr` alone → 0.
- **Tail call:** call with pc=0x40, then call+return with pc=0x80 → `or_stack=0x41`, `o_depth=1`; then a return → `or_stack=0x81`.
